// File: rtl/logiccore9_arbiter.sv
// logiccore9_arbiter: two-requester round-robin arbiter sharing one fixed-latency datapath
module logiccore9_arbiter #(
  parameter int DP_LATENCY = 6,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data0,
  output logic [WIDTH-1:0] rsp_data1,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_in1,
  output logic [WIDTH-1:0] dp_in2,
  input  logic [WIDTH-1:0] dp_result,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0] last_cnt = 8'(DP_LATENCY - 1);
  state_t state, state_nx;
  logic owner, last, win, any_req, done;
  logic [WIDTH-1:0] op1, op2, rsp;
  logic [7:0] cnt;
  always_comb begin
    any_req = req0 | req1;
    win = (req0 & req1) ? ~last : req1;
    done = cnt == last_cnt;
    state_nx = state == IDLE ? (any_req ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT ? (done ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      owner <= 1'b0;
      last <= 1'b1;
      op1 <= '0;
      op2 <= '0;
      rsp <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == WAIT && !done) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && any_req) begin
        owner <= win;
        op1 <= win ? a1 : a0;
        op2 <= win ? b1 : b0;
      end
      if (state == WAIT && done) rsp <= dp_result;
      if (state == RESP) last <= owner;
    end
  end
  assign gnt0 = state == ISSUE && !owner;
  assign gnt1 = state == ISSUE && owner;
  assign rsp_valid0 = state == RESP && !owner;
  assign rsp_valid1 = state == RESP && owner;
  assign dp_start = state == ISSUE;
  assign dp_in1 = state == ISSUE ? op1 : '0;
  assign dp_in2 = state == ISSUE ? op2 : '0;
  assign rsp_data0 = rsp;
  assign rsp_data1 = rsp;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_logiccore9_arbiter.sv
// tb_logiccore9_arbiter: randomized and directed checks against a timeline reference model
module tb_logiccore9_arbiter;
  localparam int L = 6;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, rsp_valid0, rsp_valid1, dp_start, busy;
  logic [W-1:0] rsp_data0, rsp_data1, dp_in1, dp_in2, dp_result;
  int checks = 0;
  int errors = 0;
  int dcnt = 0;
  logic [W-1:0] dsum = '0;
  bit m_act = 0;
  int m_t = 0;
  bit m_own = 0;
  bit m_last = 1;
  logic [W-1:0] m_op1 = '0, m_op2 = '0, m_rsp = '0;
  int gseq[$];
  logic [W-1:0] seen0 = '0, seen1 = '0;
  int n_gnt1 = 0;
  logiccore9_arbiter #(.DP_LATENCY(L), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .dp_start(dp_start), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_result(dp_result), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (dp_start === 1'b1) begin
      dcnt <= 1;
      dsum <= dp_in1 + dp_in2;
    end else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
  end
  assign dp_result = (dcnt == L) ? dsum : dsum ^ 8'h5A;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic chk_all();
    bit iss;
    iss = m_act && m_t == 0;
    chk("gnt", {gnt1, gnt0}, {iss && m_own, iss && !m_own});
    chk("dp_start", dp_start, iss);
    chk("dp_in1", dp_in1, iss ? m_op1 : 8'd0);
    chk("dp_in2", dp_in2, iss ? m_op2 : 8'd0);
    chk("busy", busy, m_act);
    chk("rsp_valid", {rsp_valid1, rsp_valid0}, {m_act && m_t == L + 1 && m_own, m_act && m_t == L + 1 && !m_own});
    chk("rsp_data0", rsp_data0, m_rsp);
    chk("rsp_data1", rsp_data1, m_rsp);
  endtask
  task automatic step();
    @(posedge clk);
    if (!m_act) begin
      if (req0 || req1) begin
        m_own = (req0 && req1) ? !m_last : req1;
        m_op1 = m_own ? a1 : a0;
        m_op2 = m_own ? b1 : b0;
        m_act = 1;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == L + 1) m_rsp = m_op1 + m_op2;
      if (m_t == L + 2) begin
        m_act = 0;
        m_last = m_own;
      end
    end
    #1;
    chk_all();
    if (gnt0 === 1'b1) gseq.push_back(0);
    if (gnt1 === 1'b1) begin
      gseq.push_back(1);
      n_gnt1++;
    end
    if (rsp_valid0 === 1'b1) seen0 = rsp_data0;
    if (rsp_valid1 === 1'b1) seen1 = rsp_data1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_act = 0;
    m_last = 1;
    m_rsp = '0;
    chk_all();
    #3 rst_n = 1'b1;
  endtask
  initial begin
    int g;
    @(posedge clk);
    #1;
    do_reset();
    req0 = 1; a0 = 8'd4; b0 = 8'd3;
    step();
    chk("t1_gnt0", gnt0, 1'b1);
    chk("t1_in", {dp_in1, dp_in2}, {8'd4, 8'd3});
    req0 = 0;
    repeat (L + 3) step();
    chk("t1_data", seen0, 8'd7);
    do_reset();
    req0 = 1; a0 = 8'd6; b0 = 8'hF8;
    req1 = 1; a1 = 8'hFC; b1 = 8'd3;
    step();
    chk("t2_first", gnt0, 1'b1);
    req0 = 0;
    for (g = 1; g < 50; g++) begin
      step();
      if (gnt1 === 1'b1) break;
    end
    chk("t2_gap", g, 9);
    req1 = 0;
    repeat (L + 3) step();
    chk("t2_d0", seen0, 8'hFE);
    chk("t2_d1", seen1, 8'hFF);
    gseq.delete();
    req0 = 1; req1 = 1;
    repeat (4 * (L + 3)) step();
    req0 = 0; req1 = 0;
    repeat (3) step();
    chk("t3_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk($sformatf("t3_g%0d", i), gseq[i], i % 2);
    req1 = 1; a1 = 8'hF8; b1 = 8'hFA;
    step();
    chk("t4_gnt1", gnt1, 1'b1);
    req1 = 0;
    repeat (3) step();
    n_gnt1 = 0;
    seen1 = '0;
    do_reset();
    repeat (L + 4) step();
    chk("t4_no_rsp", seen1, 8'd0);
    req1 = 1; a1 = 8'd9; b1 = 8'hFD;
    step();
    chk("t4_regnt", gnt1, 1'b1);
    req1 = 0;
    repeat (L + 3) step();
    chk("t4_data", seen1, 8'd6);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_idle", {dp_start, dp_in1, dp_in2, busy}, 18'd0);
    end
    n_gnt1 = 0;
    req0 = 1; a0 = 8'd1; b0 = 8'd2;
    step();
    req0 = 0;
    step();
    req1 = 1; a1 = 8'd5; b1 = 8'd5;
    repeat (2) step();
    req1 = 0;
    repeat (L + 4) step();
    chk("t6_no_gnt1", n_gnt1, 0);
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom % 3) != 0;
      req1 = ($urandom % 3) != 0;
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      if (i == 300) do_reset();
      step();
      chk("excl", (gnt0 & gnt1) | (rsp_valid0 & rsp_valid1), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/logiccore9_arbiter.md
LOGICCORE9_ARBITER -- requirements
Module: logiccore9_arbiter

Interface
REQ-001 SHALL have parameter DP_LATENCY, default 6, meaning clock edges from the edge that samples dp_start to dp_result being valid (legal range 1..255).
REQ-002 SHALL have parameter WIDTH, default 8, meaning operand and result width (two's-complement signed).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req0 and req1, input, 1 each, per-requester operation request.
REQ-007 SHALL have ports a0, b0, a1 and b1, input, WIDTH each, per-requester operands.
REQ-008 SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle grant pulse.
REQ-009 SHALL have ports rsp_valid0 and rsp_valid1, output, 1 each, one-cycle response pulse.
REQ-010 SHALL have ports rsp_data0 and rsp_data1, output, WIDTH each, result for the requester.
REQ-011 SHALL have port dp_start, output, 1, datapath Start.
REQ-012 SHALL have ports dp_in1 and dp_in2, output, WIDTH each, datapath Input1 and Input2.
REQ-013 SHALL have port dp_result, input, WIDTH, datapath Result.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with exactly one operation in flight.
REQ-016 SHALL, in IDLE, sample req0 and req1 at each edge; if any is high, latch the winner's operands and owner ID and go to ISSUE; otherwise remain in IDLE.
REQ-017 SHALL arbitrate round-robin when both requests are high: the winner is the requester that was not the last owner; after reset, req0 wins.
REQ-018 SHALL, in ISSUE (one cycle), assert the owner's gnt, assert dp_start, and drive dp_in1/dp_in2 with the latched operands.
REQ-019 SHALL, outside ISSUE, hold dp_start=0 and dp_in1=dp_in2=0, so no X values reach the datapath.
REQ-020 SHALL, in WAIT, count DP_LATENCY edges from the ISSUE->WAIT edge; at the final edge, capture dp_result into the response register and go to RESP.
REQ-021 SHALL, in RESP (one cycle), assert the owner's rsp_valid, update the last-owner pointer, and return to IDLE.
REQ-022 SHALL drive rsp_data0 and rsp_data1 from the response register; the value holds until the next capture and is meaningful only with the matching rsp_valid.
REQ-023 SHALL produce latency as follows: request sampled at edge E; gnt and dp_start high in the cycle after E; rsp_valid high in the cycle after edge E+1+DP_LATENCY.
REQ-024 SHALL sustain a throughput of one operation per DP_LATENCY+3 cycles.
REQ-025 SHALL ignore requests outside IDLE; a requester holds req and operands until gnt, and a req still high in IDLE is treated as a new request.
REQ-026 SHALL, when a request drops before being sampled in IDLE, issue nothing.
REQ-027 SHALL never assert gnt0 and gnt1, or rsp_valid0 and rsp_valid1, together.
REQ-028 SHALL pass operands and results through unmodified; no sign or width conversion.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: state=IDLE, pointer=req1-last (so req0 wins next), all gnt/rsp_valid/dp_start/busy=0, dp_in1=dp_in2=0, rsp_data=0, counter=0.
REQ-030 SHALL, on reset during ISSUE/WAIT/RESP, discard the in-flight operation with no rsp_valid and no pending state after release.
REQ-031 SHALL resume operation at the first rising edge after rst_n deasserts.

Verification (bench datapath model returns in1+in2 after DP_LATENCY; DP_LATENCY=6)
REQ-032 SHALL cover the single request: req0, a0=4, b0=3 sampled at edge 0 -> gnt0 and dp_start in cycle 1 with dp_in1=4, dp_in2=3; rsp_valid0 after edge 7; rsp_data0=7.
REQ-033 SHALL cover simultaneous requests after reset: req0 (6,-8) and req1 (-4,3) -> req0 served first with rsp_data0=-2; req1 served next with rsp_data1=-1; req1 gnt 9 cycles after gnt0.
REQ-034 SHALL cover fairness: both requests held continuously for 4 operations -> grants alternate 0,1,0,1; never two consecutive grants to the same requester.
REQ-035 SHALL cover reset mid-operation: req1 (-8,-6) issued, rst_n low during WAIT -> all outputs 0 immediately; no rsp_valid1; next req1-only request is served normally.
REQ-036 SHALL cover the idle check: no requests for 20 cycles -> dp_start, dp_in1, dp_in2 and busy stay 0, and outputs are never X.
REQ-037 SHALL cover a request dropped early: req1 pulsed high while busy and low again before IDLE -> no gnt1, no extra dp_start.
